cnn16_mem_ctrl: RTL and testbench

- Wait-state memory controller that sits directly downstream of the CNN-16 CPU core.
- Owns the 16-bit word RAM the core executes from and convolves over (program, image, kernel, output maps).
- Accepts single-word read/write requests from the core and returns data with a one-cycle mem_ready completion strobe.
- Provides a host load port so the bench or loader can fill memory while the core is idle.

---
 rtl/cnn16_mem_ctrl.sv | 126 ++++++++++++
 tb/tb_cnn16_mem_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cnn16_mem_ctrl.sv
// Wait-state word RAM controller for the CNN-16 core: CPU accesses complete WAIT_CYCLES
// edges after the request edge with a one-cycle mem_ready; host loads while idle.
module cnn16_mem_ctrl #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd_req,
  input  logic              cpu_wr_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic              addr_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                wr_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                ready_q;
  logic                ack_q;
  logic                err_q;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                cpu_req;
  logic                host_ok;
  logic                acc_ok;
  logic                mem_we_d;
  logic [IDX_W-1:0]    mem_idx_d;
  logic [DATA_W-1:0]   mem_wdat_d;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

  assign cpu_req = cpu_rd_req | cpu_wr_req;
  assign host_ok = in_range(host_addr);
  assign acc_ok  = in_range(addr_q);

  // Single write port shared by host loads (idle only) and the final CPU write edge.
  always_comb begin
    mem_we_d   = 1'b0;
    mem_idx_d  = '0;
    mem_wdat_d = '0;
    if (state_q == IDLE && !cpu_req && host_we && host_ok) begin
      mem_we_d   = 1'b1;
      mem_idx_d  = host_addr[IDX_W-1:0];
      mem_wdat_d = host_wdata;
    end else if (state_q == ACCESS && cnt_q == '0 && wr_q && acc_ok) begin
      mem_we_d   = 1'b1;
      mem_idx_d  = addr_q[IDX_W-1:0];
      mem_wdat_d = wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_d) mem_q[mem_idx_d] <= mem_wdat_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cpu_req) begin
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            wr_q    <= cpu_wr_req;
            cnt_q   <= CNT_INIT;
            state_q <= ACCESS;
          end else if (host_we) begin
            ack_q <= 1'b1;
            if (!host_ok) err_q <= 1'b1;
          end
        end
        ACCESS: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            if (!wr_q) rdata_q <= acc_ok ? mem_q[addr_q[IDX_W-1:0]] : '0;
            if (!acc_ok) err_q <= 1'b1;
            ready_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_rdata = rdata_q;
  assign mem_ready = ready_q;
  assign host_ack  = ack_q;
  assign addr_err  = err_q;

endmodule

// File: tb/tb_cnn16_mem_ctrl.sv
// Directed bench for cnn16_mem_ctrl: drives on the falling edge, samples on the falling edge.
module tb_cnn16_mem_ctrl;

  localparam int AW    = 12;
  localparam int DW    = 16;
  localparam int DEPTH = 2048;
  localparam int WAITC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_rd_req, cpu_wr_req;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          mem_ready;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ack;
  logic          addr_err;

  int n_chk  = 0;
  int n_fail = 0;

  cnn16_mem_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .WAIT_CYCLES(WAITC)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_rd_req(cpu_rd_req), .cpu_wr_req(cpu_wr_req),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .mem_ready(mem_ready),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic host_write(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    tick();
    chk({tag, "_ack"}, 32'(host_ack), 32'd1);
    host_we = 1'b0;
    tick();
    chk({tag, "_ack_pulse"}, 32'(host_ack), 32'd0);
  endtask

  task automatic cpu_op(input string tag, input logic rd, input logic wr,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    cpu_rd_req = rd; cpu_wr_req = wr; cpu_addr = a; cpu_wdata = d;
    tick();
    cpu_rd_req = 1'b0; cpu_wr_req = 1'b0;
    n = 0;
    while (!mem_ready && n < 8) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(WAITC));
    tick();
    chk({tag, "_rdy_pulse"}, 32'(mem_ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int seen;
    rst = 1'b0;
    cpu_rd_req = 1'b0; cpu_wr_req = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    host_we = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (3) tick();
    chk("rst_ready", 32'(mem_ready), 32'd0);
    chk("rst_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_ack",   32'(host_ack),  32'd0);
    chk("rst_err",   32'(addr_err),  32'd0);
    rst = 1'b1;
    tick();

    host_write("h000", 12'h000, 16'h1234);
    host_write("h001", 12'h001, 16'hABCD);
    host_write("h010", 12'h010, 16'h1111);
    host_write("h200", 12'h200, 16'h2222);
    cpu_op("rd001", 1'b1, 1'b0, 12'h001, 16'h0);
    chk("rd001_data", 32'(cpu_rdata), 32'hABCD);

    // Reset lands while the write sits one edge before its write edge.
    cpu_wr_req = 1'b1; cpu_addr = 12'h010; cpu_wdata = 16'hBEEF;
    tick();
    cpu_wr_req = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("abort_ready", 32'(mem_ready), 32'd0);
    chk("abort_rdata", 32'(cpu_rdata), 32'd0);
    tick();
    chk("abort_ready2", 32'(mem_ready), 32'd0);
    rst = 1'b1;
    tick();
    cpu_op("rd010", 1'b1, 1'b0, 12'h010, 16'h0);
    chk("rd010_data", 32'(cpu_rdata), 32'h1111);

    cpu_op("wr0ff", 1'b0, 1'b1, 12'h0FF, 16'h5A5A);
    chk("wr0ff_rdata_hold", 32'(cpu_rdata), 32'h1111);
    cpu_op("rd0ff", 1'b1, 1'b0, 12'h0FF, 16'h0);
    chk("rd0ff_data", 32'(cpu_rdata), 32'h5A5A);

    // Read held through the first strobe: next strobe WAITC+2 cycles later.
    cpu_rd_req = 1'b1; cpu_addr = 12'h000;
    n = 0;
    do begin tick(); n++; end while (!mem_ready && n < 10);
    chk("b2b_first", 32'(n), 32'(WAITC + 1));
    chk("b2b_data", 32'(cpu_rdata), 32'h1234);
    n = 0;
    do begin tick(); n++; end while (!mem_ready && n < 10);
    chk("b2b_spacing", 32'(n), 32'(WAITC + 2));
    cpu_rd_req = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen += int'(mem_ready);
    end
    chk("b2b_stop", 32'(seen), 32'd0);

    // Host and CPU collide: the CPU wins, host write lands once back in IDLE.
    host_we = 1'b1; host_addr = 12'h030; host_wdata = 16'h7777;
    cpu_rd_req = 1'b1; cpu_addr = 12'h001;
    tick();
    cpu_rd_req = 1'b0;
    chk("col_ack_e0", 32'(host_ack), 32'd0);
    tick();
    chk("col_ack_e1", 32'(host_ack), 32'd0);
    tick();
    chk("col_ready_e2", 32'(mem_ready), 32'd1);
    chk("col_ack_e2", 32'(host_ack), 32'd0);
    tick();
    chk("col_ack_e3", 32'(host_ack), 32'd0);
    tick();
    chk("col_ack_e4", 32'(host_ack), 32'd1);
    host_we = 1'b0;
    tick();
    chk("col_ack_pulse", 32'(host_ack), 32'd0);
    chk("col_rdata", 32'(cpu_rdata), 32'hABCD);
    cpu_op("rd030", 1'b1, 1'b0, 12'h030, 16'h0);
    chk("rd030_data", 32'(cpu_rdata), 32'h7777);

    cpu_op("both", 1'b1, 1'b1, 12'h020, 16'h0007);
    chk("both_rdata_hold", 32'(cpu_rdata), 32'h7777);
    cpu_op("rd020", 1'b1, 1'b0, 12'h020, 16'h0);
    chk("rd020_data", 32'(cpu_rdata), 32'h0007);
    chk("err_clear", 32'(addr_err), 32'd0);

    cpu_op("oor_rd", 1'b1, 1'b0, 12'h900, 16'h0);
    chk("oor_rd_data", 32'(cpu_rdata), 32'h0);
    chk("oor_rd_err", 32'(addr_err), 32'd1);
    cpu_op("rd001b", 1'b1, 1'b0, 12'h001, 16'h0);
    chk("rd001b_data", 32'(cpu_rdata), 32'hABCD);
    chk("err_sticky", 32'(addr_err), 32'd1);
    host_write("oor_host", 12'hA00, 16'hDEAD);
    cpu_op("oor_wr", 1'b0, 1'b1, 12'h810, 16'h1357);
    cpu_op("rd200", 1'b1, 1'b0, 12'h200, 16'h0);
    chk("rd200_data", 32'(cpu_rdata), 32'h2222);
    cpu_op("rd010b", 1'b1, 1'b0, 12'h010, 16'h0);
    chk("rd010b_data", 32'(cpu_rdata), 32'h1111);
    chk("err_sticky2", 32'(addr_err), 32'd1);

    rst = 1'b0;
    tick();
    chk("err_reset", 32'(addr_err), 32'd0);
    rst = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
